// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin front end letting two requesters share one ALU.
// Flow: IDLE (accept) -> EXEC (ALU evaluates) -> RESP (hold result until consumed).
// Optional build macro ALU_SHARE_ARB_OVERLAP_EN: accept the next request in the
// same cycle the current response is consumed, skipping IDLE.
module alu_share_arb (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_A,
    input  logic [63:0] req_B,
    input  logic [11:0] req_ALUFun,
    input  logic [1:0]  req_Sign,
    output logic [31:0] alu_A,
    output logic [31:0] alu_B,
    output logic [5:0]  alu_ALUFun,
    output logic        alu_Sign,
    input  logic [31:0] alu_S,
    input  logic [2:0]  alu_ZVN,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_S,
    output logic [2:0]  rsp_ZVN
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t           state;
    logic             g;        // requester owning the in-flight operation
    logic             last;     // most recently granted requester
    logic             winner;
    logic             can_take;
    logic             accept;
    logic             rsp_done;

    // per-requester operand views, index = requester number
    logic [1:0][31:0] a_l;
    logic [1:0][31:0] b_l;
    logic [1:0][5:0]  fun_l;

    assign a_l   = req_A;
    assign b_l   = req_B;
    assign fun_l = req_ALUFun;

    // Arbitration, handshake decode and response valid (decoded from registered state)
    always_comb begin
        winner   = (req_valid == 2'b11) ? ~last : req_valid[1];
        rsp_done = (state == RESP) && rsp_ready[g];
`ifdef ALU_SHARE_ARB_OVERLAP_EN
        can_take = !reset && ((state == IDLE) || rsp_done);
`else
        can_take = !reset && (state == IDLE);
`endif
        accept    = can_take && (|req_valid);
        req_ready = 2'b00;
        if (accept)
            req_ready[winner] = 1'b1;
        rsp_valid = 2'b00;
        if (state == RESP)
            rsp_valid[g] = 1'b1;
    end

    // FSM, grant tracking, operand latch and result capture
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            g          <= 1'b0;
            last       <= 1'b1;
            alu_A      <= '0;
            alu_B      <= '0;
            alu_ALUFun <= '0;
            alu_Sign   <= 1'b0;
            rsp_S      <= '0;
            rsp_ZVN    <= '0;
        end else begin
            if (accept) begin
                alu_A      <= a_l[winner];
                alu_B      <= b_l[winner];
                alu_ALUFun <= fun_l[winner];
                alu_Sign   <= req_Sign[winner];
                g          <= winner;
                last       <= winner;
            end
            case (state)
                IDLE: if (accept) state <= EXEC;
                EXEC: begin
                    rsp_S   <= alu_S;
                    rsp_ZVN <= alu_ZVN;
                    state   <= RESP;
                end
                RESP: if (rsp_done) state <= accept ? EXEC : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
